// File: rtl/mdio_cmd_sequencer.sv
// rtl/mdio_cmd_sequencer.sv - Clause-22 MDIO master that plays a command table to the PHY
// Optional read-frame capture is built only when MDIO_SEQ_READ_EN is defined.

module mdio_cmd_sequencer #(
    parameter int NUM_CMD  = 9,
    parameter int DIV      = 100,
    parameter int PRE_BITS = 32,
    parameter int GAP_BITS = 8
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  START,
    input  logic [NUM_CMD*32-1:0] CMD_TABLE,
    output logic                  MDC,
    output logic                  MDIO_OUT,
    output logic                  MDIO_OE,
    input  logic                  MDIO_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [15:0]           RD_DATA,
    output logic [7:0]            RD_IDX,
    output logic                  RD_VALID,
    output logic                  TA_ERR
);

    generate
        if (NUM_CMD < 1 || NUM_CMD > 256) begin : g_bad_num_cmd
            $error("mdio_cmd_sequencer: NUM_CMD must be 1..256");
        end
        if (DIV < 2) begin : g_bad_div
            $error("mdio_cmd_sequencer: DIV must be >= 2");
        end
    endgenerate

    localparam int          DW       = $clog2(DIV + 1);
    localparam int          BW       = 16;
    localparam logic [7:0]  LAST_IDX = 8'(NUM_CMD - 1);
    localparam logic [31:0] TERM     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_FRAME, S_GAP} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [7:0]    idx;
    logic [7:0]    nxt_idx;
    logic [31:0]   shreg;
    logic          is_rd;
    logic          tick;
    logic [31:0]   first_entry;
    logic [31:0]   cur_entry;
    logic [31:0]   nxt_entry;
    logic          cur_rd;
    logic          nxt_rd;
    logic          seq_end;

    assign tick        = (div_cnt == DW'(DIV - 1));
    assign nxt_idx     = idx + 8'd1;
    assign first_entry = CMD_TABLE[31:0];
    assign cur_entry   = CMD_TABLE[{idx, 5'd0} +: 32];
    assign nxt_entry   = CMD_TABLE[{nxt_idx, 5'd0} +: 32];
    assign seq_end     = (idx == LAST_IDX) || (nxt_entry == TERM);

`ifdef MDIO_SEQ_READ_EN
    assign cur_rd = (cur_entry[29:28] == 2'b10);
    assign nxt_rd = (nxt_entry[29:28] == 2'b10);
`else
    assign cur_rd = 1'b0;
    assign nxt_rd = 1'b0;
`endif

    // bit_cnt/state name the MDC cycle emitted at the next falling edge
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            shreg    <= '0;
            is_rd    <= 1'b0;
            MDC      <= 1'b1;
            MDIO_OUT <= 1'b1;
            MDIO_OE  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (state == S_IDLE) begin
                MDC      <= 1'b1;
                MDIO_OUT <= 1'b1;
                MDIO_OE  <= 1'b0;
                BUSY     <= 1'b0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                if (START) begin
                    idx <= 8'd0;
                    if (first_entry == TERM) begin
                        DONE <= 1'b1;
                    end else begin
                        state <= S_PRE;
                        BUSY  <= 1'b1;
                    end
                end
            end else if (!tick) begin
                div_cnt <= div_cnt + DW'(1);
            end else begin
                div_cnt <= '0;
                if (!MDC) begin
                    MDC <= 1'b1;
                end else begin
                    MDC <= 1'b0;
                    case (state)
                        S_PRE: begin
                            MDIO_OUT <= 1'b1;
                            MDIO_OE  <= 1'b1;
                            if (bit_cnt == BW'(PRE_BITS - 1)) begin
                                state   <= S_FRAME;
                                bit_cnt <= '0;
                                shreg   <= cur_entry;
                                is_rd   <= cur_rd;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                        S_FRAME: begin
                            MDIO_OUT <= shreg[31];
                            shreg    <= {shreg[30:0], 1'b0};
                            // read frames release the pad from the first turnaround bit (bit 17)
                            MDIO_OE  <= !(is_rd && bit_cnt >= BW'(14));
                            if (bit_cnt == BW'(31)) begin
                                state   <= S_GAP;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                        default: begin
                            if (bit_cnt != BW'(GAP_BITS)) begin
                                MDIO_OUT <= 1'b1;
                                MDIO_OE  <= 1'b0;
                                bit_cnt  <= bit_cnt + BW'(1);
                            end else if (seq_end) begin
                                MDC   <= 1'b1;
                                state <= S_IDLE;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end else begin
                                idx      <= nxt_idx;
                                MDIO_OUT <= 1'b1;
                                MDIO_OE  <= 1'b1;
                                if (PRE_BITS == 1) begin
                                    state   <= S_FRAME;
                                    bit_cnt <= '0;
                                    shreg   <= nxt_entry;
                                    is_rd   <= nxt_rd;
                                end else begin
                                    state   <= S_PRE;
                                    bit_cnt <= BW'(1);
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

`ifdef MDIO_SEQ_READ_EN
    logic        cap_en;
    logic [4:0]  cur_bit;
    logic [14:0] sh_in;

    // cur_bit is the frame bit on the wire; MDIO_IN is taken on the following MDC rise
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cap_en   <= 1'b0;
            cur_bit  <= '0;
            sh_in    <= '0;
            RD_DATA  <= '0;
            RD_IDX   <= '0;
            RD_VALID <= 1'b0;
            TA_ERR   <= 1'b0;
        end else begin
            RD_VALID <= 1'b0;
            if (state == S_IDLE) begin
                cap_en <= 1'b0;
                if (START) TA_ERR <= 1'b0;
            end else if (tick) begin
                if (MDC) begin
                    cap_en  <= (state == S_FRAME) && is_rd && (bit_cnt >= BW'(15));
                    cur_bit <= 5'(BW'(31) - bit_cnt);
                end else if (cap_en) begin
                    if (cur_bit == 5'd16) begin
                        if (MDIO_IN) TA_ERR <= 1'b1;
                    end else begin
                        sh_in <= {sh_in[13:0], MDIO_IN};
                        if (cur_bit == 5'd0) begin
                            RD_DATA  <= {sh_in, MDIO_IN};
                            RD_IDX   <= idx;
                            RD_VALID <= 1'b1;
                        end
                    end
                end
            end
        end
    end
`else
    logic unused_mdio_in;
    assign unused_mdio_in = MDIO_IN;
    assign RD_DATA        = '0;
    assign RD_IDX         = '0;
    assign RD_VALID       = 1'b0;
    assign TA_ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_cmd_sequencer.sv
// tb/tb_mdio_cmd_sequencer.sv - table-driven scoreboard bench for mdio_cmd_sequencer

module tb_mdio_cmd_sequencer;

    localparam int NUM_CMD   = 4;
    localparam int DIV       = 2;
    localparam int PRE_BITS  = 32;
    localparam int GAP_BITS  = 8;
    localparam int ENTRY_CLK = (PRE_BITS + 32 + GAP_BITS) * 2 * DIV;
`ifdef MDIO_SEQ_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic                  CLK = 1'b0;
    logic                  RSTn = 1'b0;
    logic                  START = 1'b0;
    logic [NUM_CMD*32-1:0] CMD_TABLE = '0;
    logic                  MDIO_IN = 1'b1;
    logic                  MDC, MDIO_OUT, MDIO_OE, BUSY, DONE, RD_VALID, TA_ERR;
    logic [15:0]           RD_DATA;
    logic [7:0]            RD_IDX;

    mdio_cmd_sequencer #(
        .NUM_CMD(NUM_CMD), .DIV(DIV), .PRE_BITS(PRE_BITS), .GAP_BITS(GAP_BITS)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .CMD_TABLE(CMD_TABLE),
        .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .MDIO_IN(MDIO_IN),
        .BUSY(BUSY), .DONE(DONE), .RD_DATA(RD_DATA), .RD_IDX(RD_IDX),
        .RD_VALID(RD_VALID), .TA_ERR(TA_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic [31:0] oe;
    } frm_t;

    typedef struct {
        logic [127:0] tbl;
        logic [15:0]  phy_data;
        logic         phy_ta;
        int           n_frames;
        int           rd_cnt;
        logic [15:0]  rd_data;
        logic [7:0]   rd_idx;
        logic         ta_err;
    } vec_t;

    frm_t        exp_q[$];
    frm_t        f;
    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_pass = 0;
    int          rise_cnt = 0;
    int          pos, npos, b;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    logic        prev_mdc = 1'b1;
    logic [31:0] pre_vec, fr_out, fr_oe;
    logic [7:0]  gap_vec;
    logic [15:0] phy_data = '0;
    logic        phy_ta = 1'b0;

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] phy,
                                       input logic [4:0] ra, input logic [1:0] ta,
                                       input logic [15:0] d);
        return {2'b01, op, phy, ra, ta, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // bus monitor, PHY model and frame scoreboard
    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (RD_VALID) rd_cnt++;
        if (!BUSY) begin
            rise_cnt = 0;
            MDIO_IN  = 1'b1;
        end else if (MDC && !prev_mdc) begin
            pos = rise_cnt % 72;
            if (pos < 32) pre_vec = {pre_vec[30:0], MDIO_OUT & MDIO_OE};
            else if (pos < 64) begin
                fr_out = {fr_out[30:0], MDIO_OUT};
                fr_oe  = {fr_oe[30:0], MDIO_OE};
            end else gap_vec = {gap_vec[6:0], MDIO_OE | !MDIO_OUT};
            if (pos == 71) begin
                if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
                else begin
                    f = exp_q.pop_front();
                    chk("frame_data", fr_out & fr_oe, f.data & f.oe);
                    chk("frame_oe", fr_oe, f.oe);
                    chk("preamble", pre_vec, 32'hFFFF_FFFF);
                    chk("gap", {24'd0, gap_vec}, 32'd0);
                end
            end
            rise_cnt++;
        end else if (!MDC && prev_mdc) begin
            npos = rise_cnt % 72;
            if (npos >= 32 && npos < 64) begin
                b = 63 - npos;
                MDIO_IN = (b == 16) ? phy_ta : (b < 16) ? phy_data[b] : 1'b1;
            end else MDIO_IN = 1'b1;
        end
        prev_mdc = MDC;
    end

    task automatic run_vec(input int i, input bit extra);
        vec_t        v;
        logic [31:0] e;
        int          cyc, ff, dl, exp_lat;
        v = vecs[i];
        CMD_TABLE = v.tbl;
        phy_data  = v.phy_data;
        phy_ta    = v.phy_ta;
        exp_q.delete();
        for (int k = 0; k < NUM_CMD; k++) begin
            e = v.tbl[32*k +: 32];
            if (e == 32'hFFFF_FFFF) break;
            exp_q.push_back('{data: e,
                              oe: (RD_EN && e[29:28] == 2'b10) ? 32'hFFFC_0000 : 32'hFFFF_FFFF});
        end
        done_cnt = 0;
        rd_cnt   = 0;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        cyc = 1; ff = 0; dl = 0;
        chk($sformatf("v%0d_ta_clear", i), TA_ERR, 0);
        while (cyc < 4000) begin
            if (!MDC && ff == 0) ff = cyc;
            if (DONE) begin
                dl = cyc;
                break;
            end
            START = extra && (cyc == 100);
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        exp_lat = (v.n_frames == 0) ? 1 : DIV + 1 + v.n_frames * ENTRY_CLK;
        chk($sformatf("v%0d_done_latency", i), dl, exp_lat);
        if (v.n_frames > 0) chk($sformatf("v%0d_first_fall", i), ff, DIV + 1);
        repeat (20) @(negedge CLK);
        chk($sformatf("v%0d_done_count", i), done_cnt, 1);
        chk($sformatf("v%0d_busy", i), BUSY, 0);
        chk($sformatf("v%0d_mdc_idle", i), MDC, 1);
        chk($sformatf("v%0d_oe_idle", i), MDIO_OE, 0);
        chk($sformatf("v%0d_frames_left", i), exp_q.size(), 0);
        chk($sformatf("v%0d_rd_valid_count", i), rd_cnt, v.rd_cnt);
        chk($sformatf("v%0d_ta_err", i), TA_ERR, v.ta_err);
        if (v.rd_cnt > 0) begin
            chk($sformatf("v%0d_rd_data", i), RD_DATA, v.rd_data);
            chk($sformatf("v%0d_rd_idx", i), RD_IDX, v.rd_idx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0, w1, w2, w3, rde, term;
        w0   = mk(2'b01, 5'd1, 5'd4, 2'b10, 16'h01E1);
        w1   = mk(2'b01, 5'd1, 5'd9, 2'b10, 16'h0300);
        w2   = mk(2'b01, 5'd1, 5'd0, 2'b10, 16'h1200);
        w3   = mk(2'b01, 5'd1, 5'd0, 2'b10, 16'h9140);
        rde  = mk(2'b10, 5'd3, 5'd2, 2'b11, 16'h0000);
        term = 32'hFFFF_FFFF;

        vecs[0] = '{{w3, w2, w1, w0},   16'h0000, 1'b0, 4, 0, 16'h0000, 8'd0, 1'b0};
        vecs[1] = '{{w3, term, w1, w0}, 16'h0000, 1'b0, 2, 0, 16'h0000, 8'd0, 1'b0};
        vecs[1].tbl = {w3, w2, term, w0};
        vecs[1].n_frames = 1;
        vecs[2] = '{{w3, w2, term, rde}, 16'h2000, 1'b0, 1, RD_EN ? 1 : 0,
                    16'h2000, 8'd0, 1'b0};
        vecs[3] = '{{w3, w2, term, rde}, 16'hFFFF, 1'b1, 1, RD_EN ? 1 : 0,
                    16'hFFFF, 8'd0, RD_EN};
        vecs[4] = '{{w3, rde, w1, w0},  16'hA5C3, 1'b0, 4, RD_EN ? 1 : 0,
                    16'hA5C3, 8'd2, 1'b0};
        vecs[5] = '{{term, w2, w1, term}, 16'h0000, 1'b0, 0, 0, 16'h0000, 8'd0, 1'b0};

        repeat (3) @(negedge CLK);
        chk("rst_mdc", MDC, 1);
        chk("rst_mdio_out", MDIO_OUT, 1);
        chk("rst_oe", MDIO_OE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_rd", {RD_VALID, TA_ERR, RD_IDX, RD_DATA}, 0);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_mdc", MDC, 1);

        for (int i = 0; i < 6; i++) run_vec(i, 1'b0);
        run_vec(0, 1'b1);

        // reset in the middle of the first frame
        CMD_TABLE = vecs[0].tbl;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (199) @(negedge CLK);
        chk("mid_busy", BUSY, 1);
        chk("mid_oe", MDIO_OE, 1);
        chk("mid_mdc", MDC, 0);
        #1 RSTn = 1'b0;
        #1;
        chk("async_rst_mdc", MDC, 1);
        chk("async_rst_oe", MDIO_OE, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_out", MDIO_OUT, 1);
        @(negedge CLK);
        RSTn = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge CLK);
        run_vec(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
